// File: rtl/hilo_unit.sv
// Execute-stage HI/LO register unit: sequences MULT/DIV commits, MTHI/MTLO writes
// and MFHI/MFLO reads, stalling the execute stage until multi-cycle results land.
module hilo_unit #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic [7:0]  hilo_op,
  input  logic [31:0] src1,
  input  logic [63:0] mul_res,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  input  logic        flush,
  output logic        hilo_stall,
  output logic        div_cancel,
  output logic [31:0] rdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  localparam int unsigned CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          stall, cancel;

  // Isolate the lowest set bit so a multi-hot op decodes deterministically.
  logic [7:0] op_sel;
  logic       op_mul, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo;

  assign op_sel  = hilo_op & (~hilo_op + 8'd1);
  assign op_mul  = op_sel[0] | op_sel[1];
  assign op_div  = op_sel[2] | op_sel[3];
  assign op_mthi = op_sel[4];
  assign op_mtlo = op_sel[5];
  assign op_mfhi = op_sel[6];
  assign op_mflo = op_sel[7];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall   = 1'b0;
    cancel  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (flush) begin
          cancel = es_valid & op_div;
        end else if (es_valid) begin
          if (op_mul) begin
            if (MUL_LAT == 0) begin
              {hi_d, lo_d} = mul_res;
            end else begin
              stall   = 1'b1;
              state_d = MUL_WAIT;
            end
          end else if (op_div) begin
            if (div_complete) begin
              hi_d = div_r;
              lo_d = div_q;
            end else begin
              stall   = 1'b1;
              state_d = DIV_WAIT;
            end
          end else if (op_mthi) begin
            hi_d = src1;
          end else if (op_mtlo) begin
            lo_d = src1;
          end
        end
      end
      MUL_WAIT: begin
        if (flush | ~es_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = mul_res;
          state_d      = IDLE;
          cnt_d        = '0;
        end else begin
          stall = 1'b1;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        end
      end
      DIV_WAIT: begin
        if (flush | ~es_valid) begin
          cancel  = 1'b1;
          state_d = IDLE;
        end else if (div_complete) begin
          hi_d    = div_r;
          lo_d    = div_q;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Control outputs are forced quiet while reset is held.
  assign hilo_stall = stall & ~reset;
  assign div_cancel = cancel & ~reset;
  assign rdata      = reset   ? '0   :
                      op_mfhi ? hi_q :
                      op_mflo ? lo_q : '0;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage HI/LO register unit. It sits directly downstream of the ALU and consumes its 64-bit multiply result and its divider quotient, remainder and complete flag.
- It sequences MULT/MULTU/DIV/DIVU commits and stalls the execute stage until each result is ready.
- It executes MTHI/MTLO writes and supplies the MFHI/MFLO read data.
- It owns the architectural HI and LO registers.

Parameters:
- MUL_LAT, 1: cycles from MULT issue until mul_res is valid (0 means combinational).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- es_valid  in  1  execute stage holds a valid instruction.
- hilo_op  in  8  one-hot: [0]mult [1]multu [2]div [3]divu [4]mthi [5]mtlo [6]mfhi [7]mflo.
- src1  in  32  rs value, used by MTHI/MTLO.
- mul_res  in  64  multiplier product {hi,lo}.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.
- div_complete  in  1  divider result valid this cycle.
- flush  in  1  exception/eret flush from a later stage; cancels the current op.
- hilo_stall  out  1  execute stage must hold its instruction and operands.
- div_cancel  out  1  abort the in-flight divide.
- rdata  out  32  MFHI/MFLO read data.
- hi_out  out  32  current HI.
- lo_out  out  32  current LO.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: HI=LO=0; state IDLE; cnt=0; hilo_stall=0; div_cancel=0; busy=0; rdata=0.
- Reset mid-operation: return to IDLE with no write.
- States: IDLE, MUL_WAIT, DIV_WAIT. cnt width is clog2(MUL_LAT+1); cnt saturates and never wraps.
- Accept condition: es_valid & |hilo_op & ~flush while in IDLE.
- Multi-hot hilo_op is illegal. The lowest set bit wins; no assertion is required.
- MTHI/MTLO: write HI (or LO) = src1 at the end of the accept cycle. No stall. State stays IDLE.
- MFHI/MFLO: rdata = HI (or LO) register value, combinational. rdata = 0 for every other op.
  - MFHI/MFLO in the cycle after an MT, MULT or DIV commit must read the new value. No bypass is needed because all writes occur at the clock edge.
- MULT/MULTU, MUL_LAT=0: write {HI,LO} = mul_res at the end of the accept cycle. No stall.
- MULT/MULTU, MUL_LAT>0: accept in cycle T.
  - hilo_stall=1 in cycles T..T+MUL_LAT-1; state MUL_WAIT with cnt counting up from 0.
  - In cycle T+MUL_LAT: hilo_stall=0, and {HI,LO} = mul_res is written at the end of that cycle.
  - Return to IDLE.
- DIV/DIVU: accept in cycle T and go to DIV_WAIT.
  - hilo_stall=1 while div_complete=0.
  - In the first cycle with div_complete=1: hilo_stall=0, LO=div_q and HI=div_r are written at the end of that cycle, and state returns to IDLE.
  - div_complete already high in cycle T: commit in cycle T with no stall.
- Operands: es holds operands stable while hilo_stall=1. The unit does not latch operands.
- flush=1 in any cycle:
  - No HI/LO write occurs that cycle.
  - hilo_stall=0 that cycle.
  - Next state is IDLE with cnt=0.
  - div_cancel = flush & (DIV_WAIT or DIV/DIVU accept attempt), one cycle.
- flush coincident with div_complete or the final MUL cycle: flush wins, and there is no write.
- es_valid dropping during MUL_WAIT/DIV_WAIT without flush: treat as a cancel (IDLE, no write, div_cancel=1 if in DIV_WAIT).
- No new op is accepted while busy=1. Ops presented during that time belong to the held instruction only.
- busy=1 in MUL_WAIT and DIV_WAIT.

Test Plan:
- Reset, then MTHI src1=0x12345678 followed by MFHI -> hilo_stall stays 0; hi_out=0x12345678 after 1 edge; rdata=0x12345678 in the MFHI cycle; LO remains 0.
- MUL_LAT=2, MULT with mul_res=0xFFFFFFFF_00000001 valid from cycle T+2 -> hilo_stall high in T and T+1, low in T+2; HI=0xFFFFFFFF, LO=0x00000001 after the T+2 edge; busy high in T+1..T+2.
- DIVU with div_complete rising 33 cycles after issue, div_q=7, div_r=3 -> stall for 33 cycles, then LO=7 and HI=3; MFLO in the next cycle returns 7.
- DIV in flight, flush asserted on cycle 10 -> div_cancel=1 for one cycle, hilo_stall=0, HI/LO unchanged; a later div_complete pulse causes no write.
- flush coincident with div_complete=1, and separately reset asserted mid MUL_WAIT -> no HI/LO update; state IDLE; after the reset case HI=LO=0.
- MUL_LAT=0 MULTU back-to-back with MTLO 0xA5A5A5A5 -> no stall; after 2 edges LO=0xA5A5A5A5 and HI equals the product's high word.
